// File: rtl/rate_tick_selector_if.sv
// -----------------------------------------------------------------------------
// rate_tick_selector_if
//   Groups the rate-selection controls and the tick/status outputs of
//   rate_tick_selector into one bundle.
//
//   Signals
//     sel             requested rate index
//     pause           1 = hold the divider, suppress tick
//     restart         1 = clear the divider, apply sel immediately
//     tick            one-cycle clock-enable pulse
//     active_sel      rate index currently in force
//     switch_pending  a valid sel differs from active_sel
//
//   Modports
//     master  drives the controls, observes tick/status (the user)
//     slave   receives the controls, drives tick/status (the selector)
// -----------------------------------------------------------------------------
interface rate_tick_selector_if #(
  parameter int SEL_W = 1
) ();

  logic [SEL_W-1:0] sel;
  logic             pause;
  logic             restart;
  logic             tick;
  logic [SEL_W-1:0] active_sel;
  logic             switch_pending;

  modport master (
    output sel,
    output pause,
    output restart,
    input  tick,
    input  active_sel,
    input  switch_pending
  );

  modport slave (
    input  sel,
    input  pause,
    input  restart,
    output tick,
    output active_sel,
    output switch_pending
  );

endinterface

// File: rtl/rate_tick_selector.sv
// -----------------------------------------------------------------------------
// rate_tick_selector
//   Single-clock rate generator. Emits a registered one-cycle enable pulse
//   (tick) at one of NUM_RATES divided rates of clk. A requested rate change
//   is only applied on a period boundary, so no period is ever truncated or
//   stretched; restart clears the divider and applies the request at once.
//
//   Ports
//     clk   system clock
//     rst   synchronous reset, active-high
//     bus   rate_tick_selector_if.slave: sel, pause, restart in;
//           tick, active_sel, switch_pending out
//
//   Parameters
//     NUM_RATES  number of selectable rates (1..2**SEL_W)
//     SEL_W      width of sel / active_sel
//     CNT_W      divider counter width
//     DIVS       packed divisors, rate i = DIVS[i*CNT_W +: CNT_W]; 0 acts as 1
//     RESET_SEL  rate index in force after reset
//
//   Build option
//     RATE_SEL_SYNC_EN  when defined, sel passes a 2-flop synchroniser
//                       (reset to RESET_SEL) before use, for asynchronous
//                       switch inputs; otherwise sel is used directly and
//                       must be synchronous to clk.
// -----------------------------------------------------------------------------
module rate_tick_selector #(
  parameter int                         NUM_RATES = 2,
  parameter int                         SEL_W     = 1,
  parameter int                         CNT_W     = 27,
  parameter logic [NUM_RATES*CNT_W-1:0] DIVS      = {27'd100_000_000, 27'd10_000_000},
  parameter int                         RESET_SEL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  rate_tick_selector_if.slave  bus
);

  localparam int               NUM_SLOTS   = 1 << SEL_W;
  localparam logic [SEL_W-1:0] RESET_SEL_V = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]   NUM_RATES_V = (SEL_W + 1)'(NUM_RATES);

  // ---------------------------------------------------------------------------
  // Divisor table. Every index reachable by a SEL_W-bit value gets an entry so
  // the lookup never leaves the array; unused slots are never selected because
  // active_sel only ever takes valid values.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_tab [NUM_SLOTS];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_div
      if (gi < NUM_RATES) begin : g_used
        localparam logic [CNT_W-1:0] RAW_DIV = DIVS[gi*CNT_W +: CNT_W];
        // A zero divisor behaves exactly like a divisor of one.
        assign div_tab[gi] = (RAW_DIV == '0) ? CNT_W'(1) : RAW_DIV;
      end else begin : g_unused
        assign div_tab[gi] = CNT_W'(1);
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Rate request, optionally synchronised.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] sel_s;

`ifdef RATE_SEL_SYNC_EN
  logic [SEL_W-1:0] sel_meta_reg;
  logic [SEL_W-1:0] sel_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_meta_reg <= RESET_SEL_V;
      sel_sync_reg <= RESET_SEL_V;
    end else begin
      sel_meta_reg <= bus.sel;
      sel_sync_reg <= sel_meta_reg;
    end
  end

  assign sel_s = sel_sync_reg;
`else
  assign sel_s = bus.sel;
`endif

  logic sel_valid;
  assign sel_valid = ({1'b0, sel_s} < NUM_RATES_V);

  // ---------------------------------------------------------------------------
  // Divider state
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg,            cnt_next;
  logic             tick_reg,           tick_next;
  logic [SEL_W-1:0] active_sel_reg,     active_sel_next;
  logic             switch_pending_reg, switch_pending_next;

  logic [CNT_W-1:0] div_cur;
  logic             at_boundary;

  assign div_cur = div_tab[active_sel_reg];
  // Equality only: cnt always restarts at 0 on a switch, so it can never sit
  // above the terminal count of the newly selected rate.
  assign at_boundary = (cnt_reg == (div_cur - CNT_W'(1)));

  always_comb begin
    cnt_next        = cnt_reg;
    tick_next       = 1'b0;
    active_sel_next = active_sel_reg;

    if (bus.restart) begin
      cnt_next = '0;
      if (sel_valid) begin
        active_sel_next = sel_s;
      end
    end else if (bus.pause) begin
      cnt_next = cnt_reg;
    end else if (at_boundary) begin
      // The boundary tick still belongs to the old rate; the new rate governs
      // the period that starts here.
      cnt_next  = '0;
      tick_next = 1'b1;
      if (sel_valid) begin
        active_sel_next = sel_s;
      end
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    switch_pending_next = sel_valid && (sel_s != active_sel_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg            <= '0;
      tick_reg           <= 1'b0;
      active_sel_reg     <= RESET_SEL_V;
      switch_pending_reg <= 1'b0;
    end else begin
      cnt_reg            <= cnt_next;
      tick_reg           <= tick_next;
      active_sel_reg     <= active_sel_next;
      switch_pending_reg <= switch_pending_next;
    end
  end

  assign bus.tick           = tick_reg;
  assign bus.active_sel     = active_sel_reg;
  assign bus.switch_pending = switch_pending_reg;

endmodule

// File: tb/tb_rate_tick_selector.sv
// -----------------------------------------------------------------------------
// tb_rate_tick_selector
//   Directed bench for rate_tick_selector. Main instance: NUM_RATES=4,
//   CNT_W=8, divisors rate0=10, rate1=4, rate2=1, rate3=0 (acts as 1).
//   Second instance: NUM_RATES=3 with the same lower divisors, used to show
//   that an out-of-range sel is ignored.
//   Edge numbering: edge 1 is the first posedge after rst is released; all
//   outputs are sampled 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_rate_tick_selector;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rate_tick_selector_if #(.SEL_W(2)) bus_a ();
  rate_tick_selector_if #(.SEL_W(2)) bus_b ();

  rate_tick_selector #(
    .NUM_RATES (4),
    .SEL_W     (2),
    .CNT_W     (8),
    .DIVS      ({8'd0, 8'd1, 8'd4, 8'd10}),
    .RESET_SEL (0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  rate_tick_selector #(
    .NUM_RATES (3),
    .SEL_W     (2),
    .CNT_W     (8),
    .DIVS      ({8'd1, 8'd4, 8'd10}),
    .RESET_SEL (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.sel = 2'd0; bus_a.pause = 1'b0; bus_a.restart = 1'b0;
    bus_b.sel = 2'd0; bus_b.pause = 1'b0; bus_b.restart = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset state (sel requests rate 1 while in reset) ----
    do_reset();
    bus_a.sel = 2'd1;
    rst = 1'b1;
    step();
    chk("rst_tick",    32'(bus_a.tick), 32'd0);
    chk("rst_active",  32'(bus_a.active_sel), 32'd0);
    chk("rst_pending", 32'(bus_a.switch_pending), 32'd0);
    $display("reset: tick=%0d active=%0d pending=%0d", bus_a.tick, bus_a.active_sel, bus_a.switch_pending);

    // ---- 1: rate 0 (div 10), ticks on edges 10, 20, 30 ----
    do_reset();
    for (int i = 1; i <= 35; i++) begin
      step();
      chk($sformatf("t1_tick_e%0d", i), 32'(bus_a.tick), 32'((i % 10) == 0));
    end
    chk("t1_active", 32'(bus_a.active_sel), 32'd0);
    $display("t1: 35 edges at div 10 done");

    // ---- 2: sel 0->1 after edge 3, switch at edge 10, then ticks 14, 18 ----
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("t2_tick_e%0d", i),    32'(bus_a.tick), 32'((i == 10) || (i == 14) || (i == 18)));
      chk($sformatf("t2_pend_e%0d", i),    32'(bus_a.switch_pending), 32'((i >= 4) && (i <= 9)));
      chk($sformatf("t2_active_e%0d", i),  32'(bus_a.active_sel), (i >= 10) ? 32'd1 : 32'd0);
      if (i == 3) bus_a.sel = 2'd1;
    end
    $display("t2: switch 0->1 at boundary done");

    // ---- 3: continue at rate 1 (cnt=2 after edge 20) ----
    bus_a.sel = 2'd2;
    step();                                    // cnt 3
    chk("t3_pend_to2", 32'(bus_a.switch_pending), 32'd1);
    chk("t3_tick_pre", 32'(bus_a.tick), 32'd0);
    step();                                    // boundary of rate 1
    chk("t3_tick_sw2",   32'(bus_a.tick), 32'd1);
    chk("t3_active_sw2", 32'(bus_a.active_sel), 32'd2);
    chk("t3_pend_sw2",   32'(bus_a.switch_pending), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3_tick_div1_%0d", i), 32'(bus_a.tick), 32'd1);
    end
    bus_a.sel = 2'd3;                          // div 0 behaves as 1
    step();
    chk("t3_active_sw3", 32'(bus_a.active_sel), 32'd3);
    chk("t3_tick_sw3",   32'(bus_a.tick), 32'd1);
    step();
    chk("t3_tick_div0",  32'(bus_a.tick), 32'd1);
    bus_a.sel = 2'd1;                          // immediate boundary -> rate 1
    step();
    chk("t3_active_back1", 32'(bus_a.active_sel), 32'd1);
    bus_a.sel = 2'd2;
    step();                                    // cnt 1
    chk("t3_pend_121",   32'(bus_a.switch_pending), 32'd1);
    bus_a.sel = 2'd1;
    step();                                    // cnt 2
    chk("t3_pend_clear", 32'(bus_a.switch_pending), 32'd0);
    step();                                    // cnt 3
    chk("t3_tick_mid",   32'(bus_a.tick), 32'd0);
    step();                                    // boundary
    chk("t3_tick_end",   32'(bus_a.tick), 32'd1);
    chk("t3_active_end", 32'(bus_a.active_sel), 32'd1);
    $display("t3: div1/div0 rates and 1->2->1 within a period done");

    // ---- 4a: pause on edges 5..9, first tick moves to edge 15 ----
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("t4_tick_e%0d", i), 32'(bus_a.tick), 32'(i == 15));
      if (i == 4) bus_a.pause = 1'b1;
      if (i == 9) bus_a.pause = 1'b0;
    end
    $display("t4a: pause holds divider done");

    // ---- 4b: restart on edge 7 with sel=1, tick on edge 11 ----
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 7) begin
        chk("t4_restart_active", 32'(bus_a.active_sel), 32'd1);
        chk("t4_restart_pend",   32'(bus_a.switch_pending), 32'd0);
      end
      chk($sformatf("t4b_tick_e%0d", i), 32'(bus_a.tick), 32'(i == 11));
      if (i == 6) begin
        bus_a.sel     = 2'd1;
        bus_a.pause   = 1'b1;                  // restart wins over pause
        bus_a.restart = 1'b1;
      end
      if (i == 7) begin
        bus_a.pause   = 1'b0;
        bus_a.restart = 1'b0;
      end
    end
    $display("t4b: restart applies sel immediately done");

    // ---- 5: sel=3 on a NUM_RATES=3 build is ignored ----
    do_reset();
    bus_b.sel = 2'd3;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("t5_active_e%0d", i), 32'(bus_b.active_sel), 32'd0);
      chk($sformatf("t5_pend_e%0d", i),   32'(bus_b.switch_pending), 32'd0);
      chk($sformatf("t5_tick_e%0d", i),   32'(bus_b.tick), 32'(i == 10));
    end
    $display("t5: invalid sel ignored done");

    // ---- 6: reset mid-period restores RESET_SEL and clears the divider ----
    do_reset();
    bus_a.sel     = 2'd1;
    bus_a.restart = 1'b1;
    step();
    bus_a.restart = 1'b0;
    chk("t6_active_pre", 32'(bus_a.active_sel), 32'd1);
    bus_a.sel = 2'd0;
    step();
    chk("t6_pend_pre", 32'(bus_a.switch_pending), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_tick",   32'(bus_a.tick), 32'd0);
    chk("t6_rst_active", 32'(bus_a.active_sel), 32'd0);
    chk("t6_rst_pend",   32'(bus_a.switch_pending), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t6_tick_e%0d", i), 32'(bus_a.tick), 32'(i == 10));
    end
    $display("t6: mid-period reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
